shift_reg_seq: RTL and testbench

- Parametrised successor to the team's fixed 8-bit left-shift register.
- Generalised in width and shift mode: left, right, rotate-left, rotate-right and arithmetic-right.
- Adds a counted-burst engine: a start pulse runs N single-bit shifts, with busy/done handshake and serial in/out.
- Sits in datapath test harnesses as a loadable pattern generator / serialiser.

---
 rtl/shift_reg_pkg.sv | 19 +
 rtl/shift_reg_seq_step.sv | 51 +++++
 rtl/shift_reg_seq.sv | 94 +++++++++
 tb/tb_shift_reg_seq.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the shift register sequencer and its step datapath.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package shift_reg_pkg;

    // Shift mode encoding as seen on the mode input; 5-7 are reserved.
    localparam logic [2:0] MODE_SHL = 3'd0;
    localparam logic [2:0] MODE_SHR = 3'd1;
    localparam logic [2:0] MODE_ROL = 3'd2;
    localparam logic [2:0] MODE_ROR = 3'd3;
    localparam logic [2:0] MODE_ASR = 3'd4;

    // Burst sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/shift_reg_seq_step.sv
// Single-bit shift step: computes next register value and the exiting bit.
// Latency: purely combinational.
// Backpressure: none; step_vld low flags a reserved mode (caller holds state).
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] op_nxt,
    output logic             exit_bit,
    output logic             step_vld
);

    localparam int M = WIDTH - 1;

    // Select the shifted value and the bit that leaves the register.
    always_comb begin
        op_nxt   = op;
        exit_bit = 1'b0;
        step_vld = 1'b1;
        case (mode)
            MODE_SHL: begin
                op_nxt   = {op[M-1:0], ser_in};
                exit_bit = op[M];
            end
            MODE_SHR: begin
                op_nxt   = {ser_in, op[M:1]};
                exit_bit = op[0];
            end
            MODE_ROL: begin
                op_nxt   = {op[M-1:0], op[M]};
                exit_bit = op[M];
            end
            MODE_ROR: begin
                op_nxt   = {op[0], op[M:1]};
                exit_bit = op[0];
            end
            MODE_ASR: begin
                op_nxt   = {op[M], op[M:1]};
                exit_bit = op[0];
            end
            default: begin
                step_vld = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Loadable shift register with a counted-burst engine (start -> N single-bit shifts).
// Latency: load visible next edge; burst of N finishes N edges after the start edge (done with final op).
// Backpressure: load_en/start honoured only while idle; ignored while busy.
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter int                CNT_W     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] op,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       mode_q;

    logic [WIDTH-1:0] op_nxt;
    logic             exit_bit;
    logic             step_vld;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op       (op),
        .mode     (mode_q),
        .ser_in   (ser_in),
        .op_nxt   (op_nxt),
        .exit_bit (exit_bit),
        .step_vld (step_vld)
    );

    // Burst sequencer: load/start arbitration in idle, one shift per edge while shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op        <= RESET_VAL;
            ser_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            mode_q    <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_en) begin
                        // Load wins over a coincident start, which is dropped.
                        op <= load_val;
                    end else if (start) begin
                        if (count != '0) begin
                            mode_q    <= mode;
                            remaining <= count;
                            state     <= ST_SHIFT;
                            busy      <= 1'b1;
                        end else begin
                            // Empty burst completes immediately without shifting.
                            done <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    // Reserved modes still consume the count but leave data untouched.
                    if (step_vld) begin
                        op      <= op_nxt;
                        ser_out <= exit_bit;
                    end
                    remaining <= remaining - 1'b1;
                    if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq (WIDTH=8, CNT_W=4, RESET_VAL=0).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: drives load_en/start while busy to confirm they are ignored.
module tb_shift_reg_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_en = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [2:0] mode = 3'd0;
    logic       ser_in = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic [7:0] op;
    logic       ser_out;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: what op and ser_out should currently show.
    logic [7:0] m_op = 8'h00;
    logic       m_ser = 1'b0;

    shift_reg_seq #(
        .WIDTH     (8),
        .CNT_W     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .load_val (load_val),
        .mode     (mode),
        .ser_in   (ser_in),
        .start    (start),
        .count    (count),
        .op       (op),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic model of one shift: value as an integer 0..255.
    function automatic logic [7:0] ref_next(input logic [7:0] v, input int md, input logic s);
        int x;
        int si;
        x  = int'(v);
        si = s ? 1 : 0;
        case (md)
            0: return 8'((x * 2) % 256 + si);
            1: return 8'(x / 2 + si * 128);
            2: return 8'((x * 2) % 256 + x / 128);
            3: return 8'(x / 2 + (x % 2) * 128);
            4: return 8'(x / 2 + (x / 128) * 128);
            default: return v;
        endcase
    endfunction

    function automatic logic ref_exit(input logic [7:0] v, input int md, input logic held);
        int x;
        x = int'(v);
        case (md)
            0, 2: return (x / 128) == 1;
            1, 3, 4: return (x % 2) == 1;
            default: return held;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        m_op = 8'h00;
        m_ser = 1'b0;
        vectors++;
        if ({op, ser_out, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: op=%h ser_out=%b busy=%b done=%b, expected op=00 ser_out=0 busy=0 done=0",
                     op, ser_out, busy, done);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (op !== 8'h00 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle_hold: op=%h done=%b, expected op=00 done=0", op, done);
            end
        end
    endtask

    task automatic test_rol_burst();
        load_en = 1'b1; load_val = 8'h01;
        tick();
        load_en = 1'b0;
        start = 1'b1; mode = 3'd2; count = 4'd3;
        tick();
        start = 1'b0;
        vectors++;
        if (op !== 8'h01 || busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rol_start_edge: op=%h busy=%b done=%b, expected op=01 busy=1 done=0", op, busy, done);
        end
        for (int i = 1; i <= 3; i++) begin
            ser_in = 1'($urandom);
            tick();
            vectors++;
            if (op !== 8'(1 << i) || busy !== (i < 3) || done !== (i == 3)) begin
                miscompares++;
                $display("FAIL rol_shift%0d: op=%h busy=%b done=%b, expected op=%h busy=%b done=%b",
                         i, op, busy, done, 8'(1 << i), (i < 3), (i == 3));
            end
        end
        tick();
        vectors++;
        if (op !== 8'h08 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rol_hold: op=%h done=%b busy=%b, expected op=08 done=0 busy=0", op, done, busy);
        end
    endtask

    task automatic test_shl_serial();
        int done_cnt;
        done_cnt = 0;
        load_en = 1'b1; load_val = 8'h81;
        tick();
        load_en = 1'b0;
        start = 1'b1; mode = 3'd0; count = 4'd2; ser_in = 1'b1;
        tick();
        start = 1'b0;
        tick();
        if (done) done_cnt++;
        vectors++;
        if (op !== 8'h03 || ser_out !== 1'b1) begin
            miscompares++;
            $display("FAIL shl_shift1: op=%h ser_out=%b, expected op=03 ser_out=1", op, ser_out);
        end
        tick();
        if (done) done_cnt++;
        vectors++;
        if (op !== 8'h07 || ser_out !== 1'b0) begin
            miscompares++;
            $display("FAIL shl_shift2: op=%h ser_out=%b, expected op=07 ser_out=0", op, ser_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_cnt++;
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL shl_done_count: got %0d done pulses, expected 1", done_cnt);
        end
    endtask

    task automatic test_asr_ror();
        load_en = 1'b1; load_val = 8'h80;
        tick();
        load_en = 1'b0;
        start = 1'b1; mode = 3'd4; count = 4'd7;
        tick();
        start = 1'b0;
        repeat (7) tick();
        vectors++;
        if (op !== 8'hFF || done !== 1'b1) begin
            miscompares++;
            $display("FAIL asr_fill: op=%h done=%b, expected op=ff done=1", op, done);
        end
        load_en = 1'b1; load_val = 8'hA5;
        tick();
        load_en = 1'b0;
        start = 1'b1; mode = 3'd3; count = 4'd8;
        tick();
        start = 1'b0;
        repeat (8) tick();
        vectors++;
        if (op !== 8'hA5 || ser_out !== 1'b1 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL ror_full_turn: op=%h ser_out=%b done=%b, expected op=a5 ser_out=1 done=1",
                     op, ser_out, done);
        end
        tick();
        m_op = op == 8'hA5 ? 8'hA5 : 8'hA5;
        m_ser = 1'b1;
    endtask

    task automatic test_count_zero_and_priority();
        int busy_seen;
        busy_seen = 0;
        start = 1'b1; mode = 3'd0; count = 4'd0;
        tick();
        start = 1'b0;
        if (busy) busy_seen++;
        vectors++;
        if (done !== 1'b1 || op !== 8'hA5) begin
            miscompares++;
            $display("FAIL count0_done: done=%b op=%h, expected done=1 op=a5", done, op);
        end
        tick();
        if (busy) busy_seen++;
        vectors++;
        if (done !== 1'b0 || busy_seen != 0) begin
            miscompares++;
            $display("FAIL count0_pulse: done=%b busy_seen=%0d, expected done=0 busy_seen=0", done, busy_seen);
        end
        load_en = 1'b1; load_val = 8'h3C; start = 1'b1; mode = 3'd2; count = 4'd5;
        tick();
        load_en = 1'b0; start = 1'b0;
        repeat (2) tick();
        vectors++;
        if (op !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_priority: op=%h busy=%b done=%b, expected op=3c busy=0 done=0", op, busy, done);
        end
    endtask

    task automatic test_reset_mid_burst();
        int done_seen;
        done_seen = 0;
        load_en = 1'b1; load_val = 8'h5A;
        tick();
        load_en = 1'b0;
        start = 1'b1; mode = 3'd1; count = 4'd5;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (op !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: op=%h busy=%b done=%b ser_out=%b, expected 00/0/0/0",
                     op, busy, done, ser_out);
        end
        repeat (2) begin
            tick();
            if (done) done_seen++;
        end
        rst = 1'b0;
        repeat (4) begin
            tick();
            if (done) done_seen++;
        end
        vectors++;
        if (done_seen != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: done_seen=%0d busy=%b, expected 0 and 0", done_seen, busy);
        end
        load_en = 1'b1; load_val = 8'h03;
        tick();
        load_en = 1'b0;
        start = 1'b1; mode = 3'd2; count = 4'd2;
        tick();
        start = 1'b0;
        repeat (2) tick();
        vectors++;
        if (op !== 8'h0C || done !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_burst: op=%h done=%b, expected op=0c done=1", op, done);
        end
        m_op = 8'h0C;
        m_ser = 1'b0;
    endtask

    // Random bursts, chained with no idle gap whenever no load is inserted.
    task automatic test_back_to_back();
        int md;
        int cnt;
        logic s;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_en = 1'b1; load_val = 8'($urandom);
                start = 1'($urandom);
                m_op = load_val;
                tick();
                load_en = 1'b0; start = 1'b0;
                vectors++;
                if (op !== m_op || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_load: op=%h busy=%b, expected op=%h busy=0", op, busy, m_op);
                end
            end
            md  = $urandom_range(0, 7);
            cnt = $urandom_range(0, 15);
            start = 1'b1; mode = 3'(md); count = 4'(cnt); ser_in = 1'($urandom);
            tick();
            start = 1'b0;
            vectors++;
            if (op !== m_op || ser_out !== m_ser || busy !== (cnt != 0) || done !== (cnt == 0)) begin
                miscompares++;
                $display("FAIL rand_start: md=%0d cnt=%0d op=%h ser_out=%b busy=%b done=%b, expected op=%h ser_out=%b busy=%b done=%b",
                         md, cnt, op, ser_out, busy, done, m_op, m_ser, (cnt != 0), (cnt == 0));
            end
            for (int i = 1; i <= cnt; i++) begin
                s = 1'($urandom);
                ser_in = s;
                mode = 3'($urandom);
                count = 4'($urandom);
                load_en = 1'($urandom);
                load_val = 8'($urandom);
                start = 1'($urandom);
                m_ser = ref_exit(m_op, md, m_ser);
                m_op  = ref_next(m_op, md, s);
                tick();
                vectors++;
                if (op !== m_op || ser_out !== m_ser || busy !== (i < cnt) || done !== (i == cnt)) begin
                    miscompares++;
                    $display("FAIL rand_shift: md=%0d step %0d/%0d op=%h ser_out=%b busy=%b done=%b, expected op=%h ser_out=%b busy=%b done=%b",
                             md, i, cnt, op, ser_out, busy, done, m_op, m_ser, (i < cnt), (i == cnt));
                end
            end
            load_en = 1'b0;
            start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_rol_burst();
        test_shl_serial();
        test_asr_ror();
        test_count_zero_and_priority();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
